// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates icache/dcache requests onto one RAM port with
// starvation protection for instruction fetches and bounded ERROR retries.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int RETRY_MAX    = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err_flag
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IGRANT = 2'd1;
  localparam logic [1:0] DGRANT = 2'd2;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int RW = (RETRY_MAX < 3) ? 2 : $clog2(RETRY_MAX + 1);
  logic [1:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [31:0]   addr_q, addr_d, store_q, store_d;
  logic          ren_q, ren_d, wen_q, wen_d, err_q, err_d;
  logic          granted, acc, erl, give_up, done, starved, go_d, go_i;
  always_comb begin
    granted  = state_q != IDLE;
    acc      = ramstate == ACCESS;
    erl      = ramstate == ERROR;
    give_up  = granted & erl & (retry_q == RW'(RETRY_MAX));
    done     = granted & (acc | give_up);
    starved  = iREN & (starve_q == SW'(STARVE_LIMIT));
    go_d     = (state_q == IDLE) & (dREN | dWEN) & ~starved;
    go_i     = (state_q == IDLE) & iREN & ~go_d;
    state_d  = go_d ? DGRANT : go_i ? IGRANT : done ? IDLE : state_q;
    // go_d with iREN high implies the counter is below the limit, so +1 saturates
    starve_d = granted ? starve_q : (~iREN | go_i) ? '0 : go_d ? starve_q + SW'(1) : starve_q;
    retry_d  = (go_d | go_i) ? '0 : (granted & erl & ~give_up) ? retry_q + RW'(1) : retry_q;
    addr_d   = go_d ? daddr : go_i ? iaddr : addr_q;
    store_d  = go_d ? dstore : store_q;
    ren_d    = go_d ? dREN : go_i ? 1'b1 : ren_q;
    wen_d    = go_d ? dWEN : go_i ? 1'b0 : wen_q;
    err_d    = err_q | give_up;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      retry_q  <= '0;
      addr_q   <= '0;
      store_q  <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      retry_q  <= retry_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      err_q    <= err_d;
    end
  end
  assign ramREN   = granted & ren_q;
  assign ramWEN   = granted & wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign err_flag = err_q;
  assign iwait    = ~((state_q == IGRANT) & done);
  assign dwait    = ~((state_q == DGRANT) & done);
  assign iload    = ((state_q == IGRANT) & acc) ? ramload : '0;
  assign dload    = ((state_q == DGRANT) & acc) ? ramload : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a transaction-level reference model
// compared every cycle, plus hand-computed literal checks.
module tb_mem_arbiter;
  localparam int SL = 4;
  localparam int RM = 3;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  logic CLK = 0, nRST = 1, iREN = 0, dREN = 0, dWEN = 0;
  logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ramload = 0;
  logic [1:0] ramstate = FREE;
  logic iwait, dwait, ramREN, ramWEN, err_flag;
  logic [31:0] iload, dload, ramaddr, ramstore;
  int tests = 0, fails = 0;
  mem_arbiter #(.STARVE_LIMIT(SL), .RETRY_MAX(RM)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err_flag(err_flag)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  // Reference: which requester owns the RAM (0 none, 1 instr, 2 data) and its captured request
  int m_gnt = 0, m_errs = 0, m_starve = 0;
  logic [31:0] m_addr = 0, m_store = 0;
  bit m_wr = 0, m_err = 0;
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_gnt = 0; m_errs = 0; m_starve = 0; m_addr = 0; m_store = 0; m_wr = 0; m_err = 0;
    end else if (m_gnt == 0) begin
      if ((dREN || dWEN) && !(iREN && m_starve == SL)) begin
        m_gnt = 2; m_addr = daddr; m_store = dstore; m_wr = dWEN; m_errs = 0;
        m_starve = iREN ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
      end else if (iREN) begin
        m_gnt = 1; m_addr = iaddr; m_errs = 0; m_starve = 0;
      end else m_starve = 0;
    end else if (ramstate == ACCESS) m_gnt = 0;
    else if (ramstate == ERROR) begin
      if (m_errs == RM) begin m_err = 1; m_gnt = 0; end
      else m_errs++;
    end
  end
  always @(negedge CLK) begin
    bit fin;
    logic [31:0] ld;
    fin = m_gnt != 0 && (ramstate == ACCESS || (ramstate == ERROR && m_errs == RM));
    ld = (fin && ramstate == ACCESS) ? ramload : 32'h0;
    chk("m_iwait", iwait, !(fin && m_gnt == 1));
    chk("m_dwait", dwait, !(fin && m_gnt == 2));
    chk("m_iload", iload, (m_gnt == 1) ? ld : 32'h0);
    chk("m_dload", dload, (m_gnt == 2) ? ld : 32'h0);
    chk("m_ramREN", ramREN, m_gnt == 1 || (m_gnt == 2 && !m_wr));
    chk("m_ramWEN", ramWEN, m_gnt == 2 && m_wr);
    chk("m_err_flag", err_flag, m_err);
    if (m_gnt != 0 || !nRST) chk("m_ramaddr", ramaddr, m_addr);
    if ((m_gnt == 2 && m_wr) || !nRST) chk("m_ramstore", ramstore, m_store);
  end
  initial begin
    int nd, d_before;
    #2 nRST = 0;
    @(negedge CLK);
    chk("rst_iwait", iwait, 1); chk("rst_dwait", dwait, 1); chk("rst_ramaddr", ramaddr, 0);
    step(); nRST = 1;
    // single instruction read with two BUSY cycles
    iREN = 1; iaddr = 32'h100; ramstate = BUSY;
    step(); iREN = 0;
    repeat (2) begin
      @(negedge CLK); chk("i_busy_ramaddr", ramaddr, 32'h100); chk("i_busy_iwait", iwait, 1);
      step();
    end
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    @(negedge CLK);
    chk("i_iwait", iwait, 0); chk("i_iload", iload, 32'hDEADBEEF); chk("i_ramREN", ramREN, 1);
    step(); ramstate = FREE;
    @(negedge CLK); chk("i_idle_ramREN", ramREN, 0);
    // simultaneous write and fetch: data first
    step(); iREN = 1; iaddr = 32'h104; dWEN = 1; daddr = 32'h200; dstore = 32'h12345678;
    step(); dWEN = 0; ramstate = ACCESS; ramload = 32'h55;
    @(negedge CLK);
    chk("w_ramWEN", ramWEN, 1); chk("w_ramstore", ramstore, 32'h12345678);
    chk("w_ramaddr", ramaddr, 32'h200); chk("w_dwait", dwait, 0); chk("w_iwait", iwait, 1);
    step(); ramload = 32'hCAFE0001;
    @(negedge CLK); chk("w_gap_iwait", iwait, 1);
    step();
    @(negedge CLK);
    chk("w_i_ramaddr", ramaddr, 32'h104); chk("w_i_iwait", iwait, 0); chk("w_i_iload", iload, 32'hCAFE0001);
    step(); iREN = 0; ramstate = FREE;
    step();
    // starvation: four data grants, then the fetch
    iREN = 1; dREN = 1; iaddr = 32'h400; daddr = 32'h500; ramstate = ACCESS; ramload = 32'h11110000;
    nd = 0; d_before = -1;
    for (int k = 0; k < 14; k++) begin
      @(negedge CLK);
      if (!dwait) nd++;
      if (!iwait && d_before < 0) d_before = nd;
    end
    chk("starve_dgrants", d_before, 4);
    step(); iREN = 0; dREN = 0;
    step(); step(); ramstate = FREE;
    // ERROR retries exhausted
    dREN = 1; daddr = 32'h600; ramstate = ERROR; ramload = 32'hBAD;
    step(); dREN = 0;
    repeat (3) begin
      @(negedge CLK); chk("e_retry_dwait", dwait, 1); chk("e_retry_err", err_flag, 0);
      step();
    end
    @(negedge CLK); chk("e_dwait", dwait, 0); chk("e_dload", dload, 0);
    step(); ramstate = FREE;
    @(negedge CLK); chk("e_err_flag", err_flag, 1); chk("e_idle_ramREN", ramREN, 0);
    // address latched despite daddr change
    dREN = 1; daddr = 32'h200; ramstate = BUSY;
    step(); daddr = 32'h300;
    repeat (2) begin
      @(negedge CLK); chk("l_ramaddr", ramaddr, 32'h200);
      step();
    end
    ramstate = ACCESS; ramload = 32'h77; dREN = 0;
    @(negedge CLK);
    chk("l_dwait", dwait, 0); chk("l_dload", dload, 32'h77); chk("l_done_ramaddr", ramaddr, 32'h200);
    step(); ramstate = FREE;
    // reset mid-grant
    dREN = 1; daddr = 32'h800; ramstate = BUSY;
    step();
    @(negedge CLK); chk("r_pre_ramREN", ramREN, 1);
    #2 nRST = 0; ramstate = ACCESS;
    #1;
    chk("r_ramREN", ramREN, 0); chk("r_ramaddr", ramaddr, 0); chk("r_ramstore", ramstore, 0);
    chk("r_dwait", dwait, 1); chk("r_err_flag", err_flag, 0);
    repeat (2) begin @(negedge CLK); chk("r_hold_dwait", dwait, 1); end
    step(); nRST = 1;
    @(negedge CLK); chk("r_idle_dwait", dwait, 1);
    step(); dREN = 0; ramload = 32'h99;
    @(negedge CLK); chk("r_after_dwait", dwait, 0); chk("r_after_dload", dload, 32'h99);
    step(); ramstate = FREE;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
